// File: rtl/pc_fetch.sv
// pc_fetch: single-stage instruction fetch with CALL/RET return-address storage and HALT.
// Build option FETCH_RAS_EN selects a 4-entry return stack; otherwise a single link register.

module pc_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [4:0]  branch_target,
   output logic [4:0]  adr,
   output logic [15:0] if_instr,
   output logic [4:0]  if_pc,
   output logic        if_valid,
   output logic        halted,
   output logic        ras_err
);

   // Handshake: if_valid qualifies if_instr/if_pc. While stall is high the PC and the
   // fetch register hold, so a live word stays presented until the cycle stall drops.

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t      state;
   logic [4:0]  pc;
   logic [4:0]  pc_inc;
   logic [4:0]  ret_addr;
   logic        is_call;
   logic        is_ret;
   logic        is_halt;
   logic        fetch_go;
   logic        do_push;
   logic        do_pop;

   assign adr    = pc;
   assign pc_inc = pc + 5'd1;
   assign halted = (state == S_HALT);

   // 16'hFFFF also fits the RET pattern; it is kept out of RET so HALTI stays reachable.
   assign is_halt = (instr == 16'hFFFF);
   assign is_call = (instr[15:10] == 6'b000000) && (instr[4:0] == 5'b11011);
   assign is_ret  = (instr[15:10] == 6'b111111) && (instr[4:0] == 5'b11111) && !is_halt;

   assign fetch_go = (state == S_RUN) && !branch_taken && !stall;
   assign do_push  = fetch_go && is_call;
   assign do_pop   = fetch_go && is_ret;

`ifdef FETCH_RAS_EN
   logic [4:0] stk [4];
   logic [2:0] cnt;
   logic [1:0] top;
   logic       err_q;

   // cnt==4 wraps cnt[1:0] to 0, so top lands on entry 3 as intended.
   assign top      = cnt[1:0] - 2'd1;
   assign ret_addr = (cnt == 3'd0) ? 5'd0 : stk[top];
   assign ras_err  = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= 3'd0;
         err_q <= 1'b0;
         for (int i = 0; i < 4; i++) stk[i] <= 5'd0;
      end else if (do_push) begin
         if (cnt == 3'd4) begin
            stk[0] <= stk[1];
            stk[1] <= stk[2];
            stk[2] <= stk[3];
            stk[3] <= pc_inc;
            err_q  <= 1'b1;
         end else begin
            stk[cnt[1:0]] <= pc_inc;
            cnt           <= cnt + 3'd1;
         end
      end else if (do_pop) begin
         if (cnt == 3'd0) begin
            err_q <= 1'b1;
         end else begin
            cnt <= cnt - 3'd1;
         end
      end
   end
`else
   logic [4:0] link;

   assign ret_addr = link;
   assign ras_err  = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         link <= 5'd0;
      end else if (do_push) begin
         link <= pc_inc;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_RUN;
         pc       <= 5'd0;
         if_instr <= 16'd0;
         if_pc    <= 5'd0;
         if_valid <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (branch_taken) begin
                  pc       <= branch_target;
                  if_valid <= 1'b0;
               end else if (!stall) begin
                  if_instr <= instr;
                  if_pc    <= pc;
                  if_valid <= 1'b1;
                  if (is_call) begin
                     pc <= instr[9:5];
                  end else if (is_ret) begin
                     pc <= ret_addr;
                  end else if (is_halt) begin
                     state <= S_HALT;
                  end else begin
                     pc <= pc_inc;
                  end
               end
            end
            S_HALT: begin
               // The halt was speculative: a redirect from execute revives fetch.
               if_valid <= 1'b0;
               if (branch_taken) begin
                  pc    <= branch_target;
                  state <= S_RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed scenarios for pc_fetch with a combinational instruction memory model.
// Expected {ras_err, halted, if_valid, if_pc, adr} tuples go through a scoreboard queue.

module tb_pc_fetch;

   localparam logic [15:0] RET_W  = 16'hFC1F;
   localparam logic [15:0] HALT_W = 16'hFFFF;
   localparam logic [15:0] NOP_W  = 16'h0001;
`ifdef FETCH_RAS_EN
   localparam logic RAS = 1'b1;
`else
   localparam logic RAS = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] instr;
   logic        stall;
   logic        branch_taken;
   logic [4:0]  branch_target;
   logic [4:0]  adr;
   logic [15:0] if_instr;
   logic [4:0]  if_pc;
   logic        if_valid;
   logic        halted;
   logic        ras_err;

   logic [15:0] mem [32];
   logic [12:0] exp_q [$];
   logic [12:0] got;
   int          errors;
   int          checks;

   pc_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .adr          (adr),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .if_valid     (if_valid),
      .halted       (halted),
      .ras_err      (ras_err)
   );

   assign instr = mem[adr];
   assign got   = {ras_err, halted, if_valid, if_pc, adr};

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [12:0] pk(input logic r, input logic h, input logic v,
                                      input logic [4:0] p, input logic [4:0] a);
      return {r, h, v, p, a};
   endfunction

   function automatic logic [15:0] callw(input logic [4:0] t);
      return {6'b000000, t, 5'b11011};
   endfunction

   task automatic init_mem();
      for (int i = 0; i < 32; i++) mem[i] = NOP_W;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      stall        = 1'b0;
      branch_taken = 1'b0;
      rst          = 1'b0;
      #2;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [12:0] e;
      init_mem();
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = 5'd0;
      rst = 1'b0;
      #2;
      exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0));
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL reset: got r/h/v/pc/adr=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                  got[12], got[11], got[10], got[9:5], got[4:0], e[12], e[11], e[10], e[9:5], e[4:0]);
      end
      checks++;
      if (if_instr !== 16'd0) begin
         errors++;
         $display("FAIL reset_instr: got %h expected 0000", if_instr);
      end
   endtask

   task automatic test_sequential();
      logic [12:0] e;
      init_mem();
      do_reset();
      for (int k = 1; k <= 33; k++) exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 5'((k - 1) % 32), 5'(k % 32)));
      for (int k = 1; k <= 33; k++) begin
         step();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL seq[%0d]: got r/h/v/pc/adr=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d", k,
                     got[12], got[11], got[10], got[9:5], got[4:0], e[12], e[11], e[10], e[9:5], e[4:0]);
         end
      end
      checks++;
      if (if_instr !== NOP_W) begin
         errors++;
         $display("FAIL seq_instr: got %h expected %h", if_instr, NOP_W);
      end
   endtask

   task automatic test_call_ret();
      logic [12:0] ex [5];
      logic [12:0] e;
      init_mem();
      mem[1]  = callw(5'd10);
      mem[11] = RET_W;
      ex[0] = pk(1'b0, 1'b0, 1'b1, 5'd0, 5'd1);
      ex[1] = pk(1'b0, 1'b0, 1'b1, 5'd1, 5'd10);
      ex[2] = pk(1'b0, 1'b0, 1'b1, 5'd10, 5'd11);
      ex[3] = pk(1'b0, 1'b0, 1'b1, 5'd11, 5'd2);
      ex[4] = pk(1'b0, 1'b0, 1'b1, 5'd2, 5'd3);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(ex[i]);
         step();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL call_ret[%0d]: got r/h/v/pc/adr=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d", i,
                     got[12], got[11], got[10], got[9:5], got[4:0], e[12], e[11], e[10], e[9:5], e[4:0]);
         end
         if (i == 1) begin
            checks++;
            if (if_instr !== 16'h015B) begin
               errors++;
               $display("FAIL call_instr: got %h expected 015b", if_instr);
            end
         end
      end
   endtask

   task automatic test_branch_stall();
      logic        st [8];
      logic        br [8];
      logic [12:0] ex [8];
      logic [12:0] e;
      init_mem();
      mem[1] = callw(5'd3);
      mem[8] = RET_W;
      branch_target = 5'd7;
      st = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      br = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ex[0] = pk(1'b0, 1'b0, 1'b1, 5'd0, 5'd1);
      ex[1] = pk(1'b0, 1'b0, 1'b1, 5'd1, 5'd3);
      ex[2] = pk(1'b0, 1'b0, 1'b0, 5'd1, 5'd7);
      ex[3] = pk(1'b0, 1'b0, 1'b1, 5'd7, 5'd8);
      ex[4] = pk(1'b0, 1'b0, 1'b1, 5'd8, 5'd2);
      ex[5] = pk(1'b0, 1'b0, 1'b1, 5'd8, 5'd2);
      ex[6] = pk(1'b0, 1'b0, 1'b1, 5'd8, 5'd2);
      ex[7] = pk(1'b0, 1'b0, 1'b1, 5'd2, 5'd3);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         stall = st[i];
         branch_taken = br[i];
         exp_q.push_back(ex[i]);
         step();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL branch_stall[%0d]: got r/h/v/pc/adr=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d", i,
                     got[12], got[11], got[10], got[9:5], got[4:0], e[12], e[11], e[10], e[9:5], e[4:0]);
         end
      end
      stall = 1'b0;
      branch_taken = 1'b0;
   endtask

   task automatic test_halt();
      logic        st [8];
      logic        br [8];
      logic [12:0] ex [8];
      logic [12:0] e;
      init_mem();
      mem[4] = HALT_W;
      branch_target = 5'd2;
      st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      br = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ex[0] = pk(1'b0, 1'b0, 1'b1, 5'd0, 5'd1);
      ex[1] = pk(1'b0, 1'b0, 1'b1, 5'd1, 5'd2);
      ex[2] = pk(1'b0, 1'b0, 1'b1, 5'd2, 5'd3);
      ex[3] = pk(1'b0, 1'b0, 1'b1, 5'd3, 5'd4);
      ex[4] = pk(1'b0, 1'b1, 1'b1, 5'd4, 5'd4);
      ex[5] = pk(1'b0, 1'b1, 1'b0, 5'd4, 5'd4);
      ex[6] = pk(1'b0, 1'b0, 1'b0, 5'd4, 5'd2);
      ex[7] = pk(1'b0, 1'b0, 1'b1, 5'd2, 5'd3);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         stall = st[i];
         branch_taken = br[i];
         exp_q.push_back(ex[i]);
         step();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL halt[%0d]: got r/h/v/pc/adr=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d", i,
                     got[12], got[11], got[10], got[9:5], got[4:0], e[12], e[11], e[10], e[9:5], e[4:0]);
         end
      end
      stall = 1'b0;
      branch_taken = 1'b0;
   endtask

   task automatic test_ras();
      logic [12:0] ex [12];
      logic [12:0] e;
      int          n;
      init_mem();
      mem[1]  = callw(5'd5);
      mem[5]  = callw(5'd9);
      mem[9]  = callw(5'd13);
      mem[13] = callw(5'd17);
      mem[17] = callw(5'd21);
      mem[21] = RET_W;
      mem[18] = RET_W;
      mem[14] = RET_W;
      mem[10] = RET_W;
      mem[6]  = RET_W;
      for (int i = 0; i < 12; i++) ex[i] = '0;
      ex[0] = pk(1'b0, 1'b0, 1'b1, 5'd0, 5'd1);
      ex[1] = pk(1'b0, 1'b0, 1'b1, 5'd1, 5'd5);
      ex[2] = pk(1'b0, 1'b0, 1'b1, 5'd5, 5'd9);
      ex[3] = pk(1'b0, 1'b0, 1'b1, 5'd9, 5'd13);
      ex[4] = pk(1'b0, 1'b0, 1'b1, 5'd13, 5'd17);
      ex[5] = pk(RAS,  1'b0, 1'b1, 5'd17, 5'd21);
      ex[6] = pk(RAS,  1'b0, 1'b1, 5'd21, 5'd18);
`ifdef FETCH_RAS_EN
      n = 12;
      ex[7]  = pk(1'b1, 1'b0, 1'b1, 5'd18, 5'd14);
      ex[8]  = pk(1'b1, 1'b0, 1'b1, 5'd14, 5'd10);
      ex[9]  = pk(1'b1, 1'b0, 1'b1, 5'd10, 5'd6);
      ex[10] = pk(1'b1, 1'b0, 1'b1, 5'd6, 5'd0);
      ex[11] = pk(1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
`else
      n = 9;
      ex[7] = pk(1'b0, 1'b0, 1'b1, 5'd18, 5'd18);
      ex[8] = pk(1'b0, 1'b0, 1'b1, 5'd18, 5'd18);
`endif
      do_reset();
      for (int i = 0; i < n; i++) begin
         if (i == 11) mem[0] = RET_W;
         exp_q.push_back(ex[i]);
         step();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL ras[%0d]: got r/h/v/pc/adr=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d", i,
                     got[12], got[11], got[10], got[9:5], got[4:0], e[12], e[11], e[10], e[9:5], e[4:0]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic        st [5];
      logic [12:0] ex [5];
      logic [12:0] e;
      init_mem();
      mem[1] = callw(5'd9);
      mem[9] = callw(5'd20);
      st = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      ex[0] = pk(1'b0, 1'b0, 1'b1, 5'd0, 5'd1);
      ex[1] = pk(1'b0, 1'b0, 1'b1, 5'd1, 5'd9);
      ex[2] = pk(1'b0, 1'b0, 1'b1, 5'd1, 5'd9);
      ex[3] = pk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      ex[4] = pk(RAS,  1'b0, 1'b1, 5'd0, 5'd0);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         stall = st[i];
         if (i == 3) begin
            // mid-cycle reset while stalled on a CALL at PC=9; checked before any edge
            #2;
            rst = 1'b0;
            #1;
            exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0));
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL async_rst: got r/h/v/pc/adr=%b/%b/%b/%0d/%0d expected 0/0/0/0/0",
                        got[12], got[11], got[10], got[9:5], got[4:0]);
            end
            checks++;
            if (if_instr !== 16'd0) begin
               errors++;
               $display("FAIL async_rst_instr: got %h expected 0000", if_instr);
            end
            @(negedge clk);
            rst = 1'b1;
         end
         if (i == 4) mem[0] = RET_W;
         exp_q.push_back(ex[i]);
         step();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL async[%0d]: got r/h/v/pc/adr=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d", i,
                     got[12], got[11], got[10], got[9:5], got[4:0], e[12], e[11], e[10], e[9:5], e[4:0]);
         end
      end
      checks++;
      if (if_instr !== RET_W) begin
         errors++;
         $display("FAIL async_ret_instr: got %h expected %h", if_instr, RET_W);
      end
      stall = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_sequential();
      test_call_ret();
      test_branch_stall();
      test_halt();
      test_ras();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
